// File: rtl/float_edit_pkg.sv
// Shared types, button indices and field arithmetic for the float register editor.
package float_edit_pkg;

    typedef enum logic [1:0] {
        FLD_EXP  = 2'b00,
        FLD_MANT = 2'b01,
        FLD_SIGN = 2'b10,
        FLD_RSV  = 2'b11
    } field_t;

    typedef enum logic [1:0] {
        RP_IDLE,
        RP_HOLD,
        RP_REPEAT
    } rep_state_t;

    localparam int BTN_UP  = 0;
    localparam int BTN_INC = 1;
    localparam int BTN_DEC = 2;
    localparam int BTN_DN  = 3;

    // +/-1 on value[lsb +: width]; wraps modulo 2^width or clamps, never touches other bits.
    function automatic logic [63:0] field_step(input logic [63:0] value, input int lsb,
                                               input int width, input logic dir,
                                               input logic saturate);
        logic [63:0] ones;
        logic [63:0] fld;
        logic [63:0] nf;
        ones = (64'd1 << width) - 64'd1;
        fld  = (value >> lsb) & ones;
        if (dir) begin
            nf = (saturate && (fld == ones)) ? fld : ((fld + 64'd1) & ones);
        end else begin
            nf = (saturate && (fld == 64'd0)) ? fld : ((fld - 64'd1) & ones);
        end
        return (value & ~(ones << lsb)) | (nf << lsb);
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// One raw active-low button -> sync, debounce, press pulse, optional auto-repeat.
// Press pulse appears 2 + DEBOUNCE_CYCLES cycles after a clean raw falling edge.
module button_conditioner
    import float_edit_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn_n,
    output logic evt
);
    localparam int DBW  = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RPW  = $clog2(RMAX + 1);

    logic           sync1;
    logic           sync2;
    logic           armed;
    logic           db_n;
    logic           press_q;
    logic [DBW-1:0] db_cnt;

    // Synchronisers reset to "pressed" so a button held through reset never arms
    // until a genuine released sample has been seen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1   <= 1'b0;
            sync2   <= 1'b0;
            armed   <= 1'b0;
            db_n    <= 1'b1;
            db_cnt  <= '0;
            press_q <= 1'b0;
        end else begin
            sync1   <= btn_n;
            sync2   <= sync1;
            armed   <= armed | sync2;
            press_q <= 1'b0;
            if (!armed || (sync2 == db_n)) begin
                db_cnt <= '0;
            end else if (db_cnt == DBW'(DEBOUNCE_CYCLES - 1)) begin
                db_cnt  <= '0;
                db_n    <= sync2;
                press_q <= !sync2;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    generate
        if (REPEAT_EN) begin : g_rep
            rep_state_t     state;
            rep_state_t     state_nxt;
            logic [RPW-1:0] rcnt;
            logic [RPW-1:0] rcnt_nxt;
            logic           rep_evt;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    state <= RP_IDLE;
                    rcnt  <= '0;
                end else begin
                    state <= state_nxt;
                    rcnt  <= rcnt_nxt;
                end
            end

            always_comb begin
                state_nxt = state;
                rcnt_nxt  = rcnt;
                rep_evt   = 1'b0;
                case (state)
                    RP_IDLE: begin
                        if (press_q) begin
                            state_nxt = RP_HOLD;
                            rcnt_nxt  = '0;
                        end
                    end
                    RP_HOLD: begin
                        if (db_n) begin
                            state_nxt = RP_IDLE;
                        end else if (rcnt == RPW'(REPEAT_DELAY - 1)) begin
                            rep_evt   = 1'b1;
                            state_nxt = RP_REPEAT;
                            rcnt_nxt  = '0;
                        end else begin
                            rcnt_nxt = rcnt + 1'b1;
                        end
                    end
                    RP_REPEAT: begin
                        if (db_n) begin
                            state_nxt = RP_IDLE;
                        end else if (rcnt == RPW'(REPEAT_PERIOD - 1)) begin
                            rep_evt  = 1'b1;
                            rcnt_nxt = '0;
                        end else begin
                            rcnt_nxt = rcnt + 1'b1;
                        end
                    end
                    default: state_nxt = RP_IDLE;
                endcase
            end

            assign evt = press_q | rep_evt;
        end else begin : g_norep
            assign evt = press_q;
        end
    endgenerate

endmodule

// File: rtl/float_reg_editor.sv
// Button/keypad editor for a bank of float registers; edits land the cycle after the event.
// UPDATE is a registered pulse alongside the first cycle a changed value is visible.
module float_reg_editor
    import float_edit_pkg::*;
#(
    parameter int N_REGS          = 2,
    parameter int WIDTH           = 32,
    parameter int EXP_LSB         = 23,
    parameter int EXP_W           = 8,
    parameter int MANT_W          = 23,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int SATURATE        = 0,
    parameter logic [WIDTH-1:0] INIT_VAL = 32'h3f800000,
    localparam int RW = (N_REGS > 1) ? $clog2(N_REGS) : 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic [3:0]              BTN_N,
    input  logic [1:0]              FIELD_SEL,
    input  logic                    LOAD_EN,
    input  logic [RW-1:0]           LOAD_IDX,
    input  logic [WIDTH-1:0]        LOAD_VAL,
    output logic [N_REGS*WIDTH-1:0] VALS,
    output logic [RW-1:0]           SEL_ROW,
    output logic                    UPDATE
);
    localparam logic [WIDTH-1:0] SIGN_MASK = {1'b1, {(WIDTH-1){1'b0}}};

    logic [3:0]       ev;
    logic [WIDTH-1:0] regs [N_REGS];
    logic [WIDTH-1:0] nxt  [N_REGS];
    logic [RW-1:0]    row;
    logic [RW-1:0]    row_nxt;
    logic             upd_q;
    logic             changed;
    logic             edit_en;
    logic             load_ok;
    logic [WIDTH-1:0] cur;
    logic [WIDTH-1:0] edited;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_btn
            button_conditioner #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
                .REPEAT_EN      ((gi == BTN_INC) || (gi == BTN_DEC)),
                .REPEAT_DELAY   (REPEAT_DELAY),
                .REPEAT_PERIOD  (REPEAT_PERIOD)
            ) u_btn (
                .clk  (CLK),
                .rst_n(RESET),
                .btn_n(BTN_N[gi]),
                .evt  (ev[gi])
            );
        end
        for (gi = 0; gi < N_REGS; gi++) begin : g_out
            assign VALS[gi*WIDTH +: WIDTH] = regs[gi];
        end
    endgenerate

    always_comb begin
        cur     = regs[row];
        edit_en = ev[BTN_INC] ^ ev[BTN_DEC];
        case (field_t'(FIELD_SEL))
            FLD_EXP:  edited = WIDTH'(field_step(64'(cur), EXP_LSB, EXP_W, ev[BTN_INC],
                                                 SATURATE != 0));
            FLD_MANT: edited = WIDTH'(field_step(64'(cur), 0, MANT_W, ev[BTN_INC],
                                                 SATURATE != 0));
            FLD_SIGN: edited = cur ^ SIGN_MASK;
            default:  edited = cur;
        endcase

        load_ok = LOAD_EN && (int'(LOAD_IDX) < N_REGS);
        nxt     = regs;
        // A load to the row being edited takes precedence; loads elsewhere coexist.
        if (edit_en && !(load_ok && (LOAD_IDX == row))) begin
            nxt[row] = edited;
        end
        if (load_ok) begin
            nxt[LOAD_IDX] = LOAD_VAL;
        end

        changed = 1'b0;
        for (int i = 0; i < N_REGS; i++) begin
            if (nxt[i] != regs[i]) begin
                changed = 1'b1;
            end
        end

        row_nxt = row;
        if (ev[BTN_UP] && !ev[BTN_DN]) begin
            row_nxt = (int'(row) == N_REGS - 1) ? '0 : row + 1'b1;
        end else if (ev[BTN_DN] && !ev[BTN_UP]) begin
            row_nxt = (row == '0) ? RW'(N_REGS - 1) : row - 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= INIT_VAL;
            end
            row   <= '0;
            upd_q <= 1'b0;
        end else begin
            regs  <= nxt;
            row   <= row_nxt;
            upd_q <= changed;
        end
    end

    assign SEL_ROW = row;
    assign UPDATE  = upd_q;

endmodule
